// File: rtl/sample_iterator.sv
// Sample iterator: latches one triangle with its bounding box and walks the box
// in raster order at the multisample pitch. It emits one sample per cycle and
// holds the upstream bounding-box stage with halt until the last sample.
module sample_iterator #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] color_R13U [COLORS],
   input  logic signed [SIGFIG-1:0] box_R13S [2][2],
   input  logic                     validTri_R13H,
   input  logic        [3:0]        subSample_RnnnnU,
   output logic                     halt_RnnnnH,
   output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
   output logic        [SIGFIG-1:0] color_R14U [COLORS],
   output logic signed [SIGFIG-1:0] sample_R14S [2],
   output logic                     validSamp_R14H
);

   typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

   state_t                   r_state;
   logic signed [SIGFIG-1:0] r_tri [VERTS][AXIS];
   logic        [SIGFIG-1:0] r_color [COLORS];
   logic signed [SIGFIG-1:0] r_ll_x, r_ll_y, r_ur_x, r_ur_y;
   logic        [SIGFIG-1:0] r_step;
   logic signed [SIGFIG-1:0] r_x, r_y;

   state_t                   w_state_nx;
   logic signed [SIGFIG-1:0] w_x_nx, w_y_nx;
   logic                     w_load;
   logic        [SIGFIG-1:0] w_step_in;
   logic signed [SIGFIG:0]   w_sum_x, w_sum_y, w_ur_x_ext, w_ur_y_ext;
   logic                     w_x_ok, w_y_ok, w_last, w_halt, w_accept, w_empty;

   // Sums carry one extra bit so a step past the positive limit still compares correctly
   assign w_sum_x    = {r_x[SIGFIG-1], r_x} + {1'b0, r_step};
   assign w_sum_y    = {r_y[SIGFIG-1], r_y} + {1'b0, r_step};
   assign w_ur_x_ext = {r_ur_x[SIGFIG-1], r_ur_x};
   assign w_ur_y_ext = {r_ur_y[SIGFIG-1], r_ur_y};
   assign w_x_ok     = (w_sum_x <= w_ur_x_ext);
   assign w_y_ok     = (w_sum_y <= w_ur_y_ext);
   assign w_last     = !w_x_ok && !w_y_ok;
   assign w_halt     = (r_state == TEST) && !w_last;
   assign w_accept   = validTri_R13H && !w_halt;
   assign w_empty    = (box_R13S[1][0] < box_R13S[0][0]) || (box_R13S[1][1] < box_R13S[0][1]);

   assign halt_RnnnnH    = w_halt;
   assign validSamp_R14H = (r_state == TEST);
   assign tri_R14S       = r_tri;
   assign color_R14U     = r_color;
   assign sample_R14S[0] = r_x;
   assign sample_R14S[1] = r_y;

   // Decode the one-hot MSAA mode into a sample pitch; anything else is 1x
   always_comb begin
      w_step_in = SIGFIG'(1) << RADIX;
      case (subSample_RnnnnU)
         4'b0100: w_step_in = SIGFIG'(1) << (RADIX - 1);
         4'b0010: w_step_in = SIGFIG'(1) << (RADIX - 2);
         4'b0001: w_step_in = SIGFIG'(1) << (RADIX - 3);
         default: w_step_in = SIGFIG'(1) << RADIX;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= WAIT;
      else      r_state <= w_state_nx;
   end

   // Next state and walk position: accept when idle or on the last sample, else advance
   always_comb begin
      w_state_nx = r_state;
      w_x_nx     = r_x;
      w_y_nx     = r_y;
      w_load     = 1'b0;
      if (r_state == WAIT || w_last) begin
         w_state_nx = WAIT;
         if (w_accept) begin
            w_load = 1'b1;
            if (!w_empty) begin
               w_state_nx = TEST;
               w_x_nx     = box_R13S[0][0];
               w_y_nx     = box_R13S[0][1];
            end
         end
      end else if (w_x_ok) begin
         w_x_nx = w_sum_x[SIGFIG-1:0];
      end else begin
         w_x_nx = r_ll_x;
         w_y_nx = w_sum_y[SIGFIG-1:0];
      end
   end

   // Triangle, box and pitch latch on accept; position updates every edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
               r_tri[v][a] <= '0;
         for (int c = 0; c < COLORS; c++)
            r_color[c] <= '0;
         r_ll_x <= '0;
         r_ll_y <= '0;
         r_ur_x <= '0;
         r_ur_y <= '0;
         r_step <= '0;
         r_x    <= '0;
         r_y    <= '0;
      end else begin
         if (w_load) begin
            r_tri   <= tri_R13S;
            r_color <= color_R13U;
            r_ll_x  <= box_R13S[0][0];
            r_ll_y  <= box_R13S[0][1];
            r_ur_x  <= box_R13S[1][0];
            r_ur_y  <= box_R13S[1][1];
            r_step  <= w_step_in;
         end
         r_x <= w_x_nx;
         r_y <= w_y_nx;
      end
   end

endmodule

// File: tb/tb_sample_iterator.sv
// Bench for sample_iterator: a sample-list reference model plus directed
// literal cases and randomized triangles.
module tb_sample_iterator;
   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic signed [SIGFIG-1:0] tri_in [VERTS][AXIS];
   logic        [SIGFIG-1:0] col_in [COLORS];
   logic signed [SIGFIG-1:0] box_in [2][2];
   logic                     validTri = 1'b0;
   logic        [3:0]        subSample = 4'b1000;
   logic                     halt;
   logic signed [SIGFIG-1:0] tri_out [VERTS][AXIS];
   logic        [SIGFIG-1:0] col_out [COLORS];
   logic signed [SIGFIG-1:0] samp_out [2];
   logic                     validSamp;

   sample_iterator #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) dut (
      .clk(clk), .rst(rst), .tri_R13S(tri_in), .color_R13U(col_in), .box_R13S(box_in),
      .validTri_R13H(validTri), .subSample_RnnnnU(subSample), .halt_RnnnnH(halt),
      .tri_R14S(tri_out), .color_R14U(col_out), .sample_R14S(samp_out), .validSamp_R14H(validSamp)
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y;} pt_t;
   typedef struct {int x; int y; bit h; int t; int n;} cap_t;

   int checks = 0;
   int failures = 0;

   // Reference model: on accept, enumerate the whole box as a list, then play it out
   pt_t                      pend[$];
   bit                       m_valid = 1'b0;
   int                       m_x = 0, m_y = 0;
   logic signed [SIGFIG-1:0] m_tri [VERTS][AXIS];
   logic        [SIGFIG-1:0] m_col [COLORS];
   int                       acc_cnt = 0;

   cap_t cap_q[$];
   int   cyc_n = 0;

   function automatic int step_of(logic [3:0] m);
      case (m)
         4'b1000: return 1 << RADIX;
         4'b0100: return 1 << (RADIX - 1);
         4'b0010: return 1 << (RADIX - 2);
         4'b0001: return 1 << (RADIX - 3);
         default: return 1 << RADIX;
      endcase
   endfunction

   initial begin
      forever begin
         pt_t p;
         int  st, llx, lly, urx, ury;
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_valid = 1'b0;
            pend.delete();
         end else if (m_valid && pend.size() > 0) begin
            p   = pend.pop_front();
            m_x = p.x;
            m_y = p.y;
         end else begin
            m_valid = 1'b0;
            if (validTri) begin
               acc_cnt++;
               m_tri = tri_in;
               m_col = col_in;
               st  = step_of(subSample);
               llx = int'(box_in[0][0]);
               lly = int'(box_in[0][1]);
               urx = int'(box_in[1][0]);
               ury = int'(box_in[1][1]);
               for (int y = lly; y <= ury; y += st)
                  for (int x = llx; x <= urx; x += st)
                     pend.push_back('{x, y});
               if (pend.size() > 0) begin
                  p       = pend.pop_front();
                  m_x     = p.x;
                  m_y     = p.y;
                  m_valid = 1'b1;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model, on the falling edge
   initial begin
      forever begin
         bit bad;
         bit mh;
         @(negedge clk);
         cyc_n++;
         checks++;
         bad = 1'b0;
         if (!rst) begin
            bad = validSamp || halt || (samp_out[0] != 0) || (samp_out[1] != 0);
            for (int v = 0; v < VERTS; v++)
               for (int a = 0; a < AXIS; a++)
                  if (tri_out[v][a] != 0) bad = 1'b1;
            for (int c = 0; c < COLORS; c++)
               if (col_out[c] != 0) bad = 1'b1;
            if (bad) begin
               failures++;
               $display("FAIL reset_outputs t=%0t valid=%0b halt=%0b x=%0d y=%0d required all zero",
                        $time, validSamp, halt, samp_out[0], samp_out[1]);
            end
         end else begin
            mh = m_valid && (pend.size() > 0);
            if (validSamp !== m_valid || halt !== mh) bad = 1'b1;
            if (m_valid) begin
               if (int'(samp_out[0]) != m_x || int'(samp_out[1]) != m_y) bad = 1'b1;
               for (int v = 0; v < VERTS; v++)
                  for (int a = 0; a < AXIS; a++)
                     if (tri_out[v][a] !== m_tri[v][a]) bad = 1'b1;
               for (int c = 0; c < COLORS; c++)
                  if (col_out[c] !== m_col[c]) bad = 1'b1;
            end
            if (bad) begin
               failures++;
               $display("FAIL model_cycle t=%0t valid=%0b/%0b halt=%0b/%0b sample=(%0d,%0d)/(%0d,%0d) tri00=%0d/%0d",
                        $time, validSamp, m_valid, halt, mh, samp_out[0], samp_out[1], m_x, m_y,
                        tri_out[0][0], m_tri[0][0]);
            end
            if (validSamp)
               cap_q.push_back('{int'(samp_out[0]), int'(samp_out[1]), halt, int'(tri_out[0][0]), cyc_n});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Present a triangle and hold it until the model reports acceptance; valid stays high
   task automatic drive(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] mode, output int cyc);
      int start;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            tri_in[v][a] = SIGFIG'($urandom);
      for (int c = 0; c < COLORS; c++)
         col_in[c] = SIGFIG'($urandom);
      box_in[0][0] = SIGFIG'(llx);
      box_in[0][1] = SIGFIG'(lly);
      box_in[1][0] = SIGFIG'(urx);
      box_in[1][1] = SIGFIG'(ury);
      subSample    = mode;
      validTri     = 1'b1;
      start        = acc_cnt;
      cyc          = 0;
      while (acc_cnt == start && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (acc_cnt == start) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=%0d cycles required=accept", cyc);
      end
   endtask

   task automatic idle(input int n);
      validTri = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int c, c2, tA, tB;
      int ex_x[6], ex_y[6], ex_h[6];
      ex_x = '{0, 1024, 2048, 0, 1024, 2048};
      ex_y = '{0, 0, 0, 1024, 1024, 1024};
      ex_h = '{1, 1, 1, 1, 1, 0};
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            tri_in[v][a] = '0;
      for (int k = 0; k < COLORS; k++) col_in[k] = '0;
      for (int k = 0; k < 2; k++) begin
         box_in[k][0] = '0;
         box_in[k][1] = '0;
      end
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_valid", validSamp, 0);
      chk("reset_halt", halt, 0);

      // 1x 3x2 walk
      cap_q.delete();
      drive(0, 0, 2048, 1024, 4'b1000, c);
      idle(8);
      chk("walk_count", cap_q.size(), 6);
      for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
         chk("walk_x", cap_q[i].x, ex_x[i]);
         chk("walk_y", cap_q[i].y, ex_y[i]);
         chk("walk_halt", cap_q[i].h, ex_h[i]);
      end

      // 4x single sample
      cap_q.delete();
      drive(1024, 1024, 1024, 1024, 4'b0100, c);
      tA = int'(tri_in[0][0]);
      idle(4);
      chk("single_count", cap_q.size(), 1);
      if (cap_q.size() == 1) begin
         chk("single_x", cap_q[0].x, 1024);
         chk("single_y", cap_q[0].y, 1024);
         chk("single_halt", cap_q[0].h, 0);
         chk("single_tri", cap_q[0].t, tA);
      end

      // back-to-back
      cap_q.delete();
      drive(0, 0, 1024, 0, 4'b1000, c);
      tA = int'(tri_in[0][0]);
      drive(4096, 4096, 4096, 4096, 4'b1000, c2);
      tB = int'(tri_in[0][0]);
      idle(4);
      chk("b2b_accept_cycles", c2, 2);
      chk("b2b_count", cap_q.size(), 3);
      if (cap_q.size() == 3) begin
         chk("b2b_x0", cap_q[0].x, 0);
         chk("b2b_x1", cap_q[1].x, 1024);
         chk("b2b_x2", cap_q[2].x, 4096);
         chk("b2b_y2", cap_q[2].y, 4096);
         chk("b2b_gap", cap_q[2].n - cap_q[0].n, 2);
         chk("b2b_triA", cap_q[1].t, tA);
         chk("b2b_triB", cap_q[2].t, tB);
      end

      // empty box then immediate next triangle
      cap_q.delete();
      drive(2048, 0, 1024, 0, 4'b1000, c);
      chk("empty_valid", validSamp, 0);
      chk("empty_halt", halt, 0);
      drive(0, 0, 0, 0, 4'b1000, c2);
      chk("empty_next_accept", c2, 1);
      idle(4);
      chk("empty_count", cap_q.size(), 1);

      // reset mid-walk
      cap_q.delete();
      drive(0, 0, 3072, 3072, 4'b1000, c);
      validTri = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mid_x", int'(samp_out[0]), 2048);
      chk("mid_y", int'(samp_out[1]), 0);
      chk("mid_halt", halt, 1);
      #1 rst = 1'b0;
      #1;
      chk("rst_valid", validSamp, 0);
      chk("rst_halt", halt, 0);
      chk("rst_x", int'(samp_out[0]), 0);
      chk("rst_tri", int'(tri_out[0][0]), 0);
      chk("rst_col", int'(col_out[0]), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      cap_q.delete();
      idle(6);
      chk("post_rst_count", cap_q.size(), 0);

      // negative coordinates at 64x
      cap_q.delete();
      drive(-1024, -1024, -896, -1024, 4'b0001, c);
      idle(4);
      chk("neg_count", cap_q.size(), 2);
      if (cap_q.size() == 2) begin
         chk("neg_x0", cap_q[0].x, -1024);
         chk("neg_x1", cap_q[1].x, -896);
         chk("neg_y1", cap_q[1].y, -1024);
      end

      // walk ending at the positive limit
      cap_q.delete();
      drive(8386560, 0, 8387584, 0, 4'b1000, c);
      idle(4);
      chk("limit_count", cap_q.size(), 2);

      // randomized triangles, mixed gaps and back-to-back
      for (int i = 0; i < 60; i++) begin
         logic [3:0] md;
         int st, llx, lly, w, h;
         case ($urandom_range(0, 4))
            0: md = 4'b1000;
            1: md = 4'b0100;
            2: md = 4'b0010;
            3: md = 4'b0001;
            default: md = 4'($urandom);
         endcase
         st  = step_of(md);
         llx = (int'($urandom_range(0, 200)) - 100) * st;
         lly = (int'($urandom_range(0, 200)) - 100) * st;
         if ($urandom_range(0, 9) == 0) llx = 8387584 - int'($urandom_range(0, 3)) * st;
         w = int'($urandom_range(0, 4)) - 1;
         h = int'($urandom_range(0, 4)) - 1;
         drive(llx, lly, llx + w * st, lly + h * st, md, c);
         if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(0, 3)));
      end
      idle(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
Upstream neighbour of the sample test stage. Accepts one triangle, its colour and its screen-space bounding box. Walks the box in raster order, one sample per cycle, at the active multisample pitch. Drives the sample test inputs (tri, colour, sample, validSamp) from registers, and holds off the bounding-box stage with halt while iterating.

Parameters:
SIGFIG, 24, bits in colour and position
RADIX, 10, fraction bits in colour and position (pixel pitch = 1<<RADIX)
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, colour channels

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
tri_R13S  in  signed SIGFIG x [VERTS][AXIS]  triangle vertices
color_R13U  in  SIGFIG x [COLORS]  triangle colour
box_R13S  in  signed SIGFIG x [2][2]  [0]=lower-left, [1]=upper-right; [n][0]=x, [n][1]=y
validTri_R13H  in  1  triangle and box valid
subSample_RnnnnU  in  4  MSAA mode, one-hot: 1000=1x, 0100=4x, 0010=16x, 0001=64x
halt_RnnnnH  out  1  high = upstream must hold its inputs
tri_R14S  out  signed SIGFIG x [VERTS][AXIS]  latched triangle
color_R14U  out  SIGFIG x [COLORS]  latched colour
sample_R14S  out  signed SIGFIG x [2]  current sample (x,y)
validSamp_R14H  out  1  sample_R14S is valid

Behaviour:
- Reset: rst low clears every register immediately (asynchronous). State=WAIT, all outputs 0, halt 0. A triangle in flight is abandoned; no further samples follow. Release: WAIT on the first edge with rst high.
- Step: 1000 -> 1<<RADIX; 0100 -> 1<<(RADIX-1); 0010 -> 1<<(RADIX-2); 0001 -> 1<<(RADIX-3). Non-one-hot values behave as 1000. Step is sampled once, at acceptance, and held for the whole triangle.
- The box is grid-aligned by upstream. No rounding is done here.
- Accept: on a clock edge with validTri_R13H=1 and halt_RnnnnH=0. The block latches tri, colour, box and step.
- State WAIT: validSamp=0. On accept with a non-empty box, the next state is TEST and sample=(LLx,LLy), validSamp=1 after the same edge. Latency from accept edge to first valid sample is 1 cycle.
- Empty box (URx<LLx or URy<LLy): the block accepts the triangle and drops it. No sample is emitted, the state stays WAIT and halt stays 0.
- State TEST: one valid sample per cycle, advanced on every edge:
  - If x+step <= URx: x += step.
  - Else, if y+step <= URy: x = LLx, y += step.
  - Else: last sample.
- Sums are computed at SIGFIG+1 bits with signed compares, so no wrap-around occurs near the positive limit.
- last = (x+step > URx) && (y+step > URy), decoded from registered state.
- halt_RnnnnH = (state==TEST) && !last. This is combinational from registers only, with no path from inputs.
- Last-sample cycle, validTri=1: the next triangle is accepted on that edge and its first sample follows with no bubble. A new empty box goes to WAIT.
- Last-sample cycle, validTri=0: next state is WAIT and validSamp=0.
- tri_R14S and color_R14U stay constant for every sample of a triangle. They hold their last value in WAIT.
- There is no downstream backpressure. The sample test accepts one sample per cycle unconditionally.
- Single-sample box (LL==UR): last=1 on the first TEST cycle, so halt never rises.

Test Plan:
- 1x, LL=(0,0), UR=(2048,1024): six consecutive samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) with validSamp=1. Halt is high for the first 5 of these cycles and low on the 6th. Then WAIT.
- 4x, LL=UR=(1024,1024): exactly one sample (1024,1024). Halt is never asserted. tri and colour outputs equal the inputs.
- Back-to-back: triangle A 1x, LL=(0,0), UR=(1024,0); triangle B held valid from the cycle after A's accept, box (4096,4096)-(4096,4096). Required output: (0,0),(1024,0),(4096,4096) in consecutive cycles. tri_R14S switches to B together with the (4096,4096) sample.
- Empty box, LL=(2048,0), UR=(1024,0): validSamp never rises, halt stays 0 and the next triangle is accepted on the following edge.
- Reset mid-walk: 1x box (0,0)-(3072,3072), rst driven low during the 3rd sample (2048,0). Required: outputs are 0 and validSamp=0 before the next edge, halt=0. After release, no samples until a new validTri.
- Negative coordinates and 64x: LL=(-1024,-1024), UR=(-896,-1024). Required samples: (-1024,-1024), (-896,-1024), then WAIT.
